stepper_pio_out: RTL and testbench

- Avalon-MM slave peripheral that drives the 4 coil lines of a unipolar stepper motor in the MotorPasso system.
- It is the output-direction counterpart of the system's input PIO.
- Software programs direction, step mode, step period and step count. The block then sequences the coil patterns autonomously and raises an interrupt when the move completes.

---
 rtl/stepper_pio_out_if.sv | 11 +
 rtl/stepper_pio_out.sv | 147 ++++++++++++++
 tb/tb_stepper_pio_out.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_pio_out_if.sv
// Avalon-MM slave register bus for the MotorPasso stepper output PIO.
interface stepper_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/stepper_pio_out.sv
// Stepper coil sequencer: software sets direction, mode, period and step count;
// the block walks the 8-entry coil table and flags completion with a level irq.
module stepper_pio_out #(
  parameter int PERIOD_W = 24,
  parameter int STEPS_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  stepper_pio_out_if.slave   bus,
  output logic               irq,
  output logic [3:0]         out_port
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_STEPS  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_PHASE  = 3'd4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic                enable, dir, half_step, irq_en, continuous;
  logic                done;
  logic [PERIOD_W-1:0] period, prescaler, eff_period;
  logic [STEPS_W-1:0]  remaining;
  logic [2:0]          index, inc, next_index;
  logic [31:0]         wdata, rd_mux;
  logic                wr_en, wr_ctrl, wr_period, wr_steps, wr_status;
  logic                tc, abort, step;
  logic                unused_wdata;

  function automatic logic [3:0] phase_pattern(input logic [2:0] i);
    case (i)
      3'd0:    phase_pattern = 4'b0001;
      3'd1:    phase_pattern = 4'b0011;
      3'd2:    phase_pattern = 4'b0010;
      3'd3:    phase_pattern = 4'b0110;
      3'd4:    phase_pattern = 4'b0100;
      3'd5:    phase_pattern = 4'b1100;
      3'd6:    phase_pattern = 4'b1000;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  assign wdata        = bus.writedata;
  assign unused_wdata = ^bus.writedata;
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl      = wr_en & (bus.address == A_CTRL);
  assign wr_period    = wr_en & (bus.address == A_PERIOD);
  assign wr_steps     = wr_en & (bus.address == A_STEPS);
  assign wr_status    = wr_en & (bus.address == A_STATUS);

  // Live compare against the current period so a shortened period fires at once.
  assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
  assign tc         = prescaler >= (eff_period - PERIOD_W'(1));
  assign abort      = wr_ctrl & ~wdata[0];
  assign step       = (state == RUN) & tc & ~wr_steps & ~abort;
  assign inc        = half_step ? 3'd1 : 3'd2;
  assign next_index = dir ? (index - inc) : (index + inc);

  assign irq = done & irq_en;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_mux = '0;
    case (bus.address)
      A_CTRL:   rd_mux[4:0]          = {continuous, irq_en, half_step, dir, enable};
      A_PERIOD: rd_mux[PERIOD_W-1:0] = period;
      A_STEPS:  rd_mux[STEPS_W-1:0]  = remaining;
      A_STATUS: rd_mux[1:0]          = {done, state == RUN};
      A_PHASE:  rd_mux[2:0]          = index;
      default:  rd_mux               = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; later statements in this
  // block deliberately override earlier ones (register writes beat the step logic).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      enable       <= 1'b0;
      dir          <= 1'b0;
      half_step    <= 1'b0;
      irq_en       <= 1'b0;
      continuous   <= 1'b0;
      done         <= 1'b0;
      period       <= '0;
      prescaler    <= '0;
      remaining    <= '0;
      index        <= '0;
      out_port     <= 4'b0000;
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
      out_port     <= enable ? phase_pattern(index) : 4'b0000;

      // Cleared before the step logic so a same-cycle completion still sets done.
      if (wr_status) done <= 1'b0;

      if (state == RUN) prescaler <= prescaler + PERIOD_W'(1);
      else              prescaler <= '0;

      if (step) begin
        prescaler <= '0;
        index     <= next_index;
        if (!continuous) begin
          remaining <= remaining - STEPS_W'(1);
          if (remaining == STEPS_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end

      if (wr_period) period <= wdata[PERIOD_W-1:0];

      if (wr_ctrl) begin
        enable     <= wdata[0];
        dir        <= wdata[1];
        half_step  <= wdata[2];
        irq_en     <= wdata[3];
        continuous <= wdata[4];
        if (!wdata[0]) begin
          state     <= IDLE;
          prescaler <= '0;
        end else if (state == IDLE && wdata[4]) begin
          state     <= RUN;
          prescaler <= '0;
        end else if (state == RUN && !wdata[4] && remaining == '0) begin
          state <= IDLE;
        end
      end

      if (wr_steps) begin
        remaining <= wdata[STEPS_W-1:0];
        prescaler <= '0;
        if (wdata[STEPS_W-1:0] == '0) begin
          if (!continuous) state <= IDLE;
        end else if (enable) begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_stepper_pio_out.sv
// Self-checking bench for stepper_pio_out: register vector table plus
// cycle-exact stepping sequences, reads scored through an expected-value queue.
module tb_stepper_pio_out;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq;
  logic [3:0] out_port;

  stepper_pio_out_if bus();

  stepper_pio_out #(.PERIOD_W(24), .STEPS_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .irq      (irq),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] sb[$];
  vec_t        vecs[$];

  function automatic logic [3:0] coil(input int i);
    case (i % 8)
      0:       coil = 4'b0001;
      1:       coil = 4'b0011;
      2:       coil = 4'b0010;
      3:       coil = 4'b0110;
      4:       coil = 4'b0100;
      5:       coil = 4'b1100;
      6:       coil = 4'b1000;
      default: coil = 4'b1001;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // All tasks start and end on a falling edge; the write lands on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    bus.chipselect = 1'b0;
    check(name, bus.readdata, sb.pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset values while reset is held.
    @(negedge clk);
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    // Register map vectors: reset reads of every address, then write/readback.
    for (int a = 0; a < 8; a++) vecs.push_back('{addr: 3'(a), wr: 1'b0, wdata: 32'h0, exp: 32'h0});
    vecs.push_back('{addr: 3'd0, wr: 1'b1, wdata: 32'h0000_001C, exp: 32'h0});
    vecs.push_back('{addr: 3'd0, wr: 1'b0, wdata: 32'h0,         exp: 32'h0000_001C});
    vecs.push_back('{addr: 3'd1, wr: 1'b1, wdata: 32'hABCD_EF12, exp: 32'h0});
    vecs.push_back('{addr: 3'd1, wr: 1'b0, wdata: 32'h0,         exp: 32'h00CD_EF12});
    vecs.push_back('{addr: 3'd2, wr: 1'b1, wdata: 32'h0001_2345, exp: 32'h0});
    vecs.push_back('{addr: 3'd2, wr: 1'b0, wdata: 32'h0,         exp: 32'h0000_2345});
    vecs.push_back('{addr: 3'd3, wr: 1'b0, wdata: 32'h0,         exp: 32'h0});
    vecs.push_back('{addr: 3'd4, wr: 1'b0, wdata: 32'h0,         exp: 32'h0});
    vecs.push_back('{addr: 3'd5, wr: 1'b1, wdata: 32'hFFFF_FFFF, exp: 32'h0});
    vecs.push_back('{addr: 3'd5, wr: 1'b0, wdata: 32'h0,         exp: 32'h0});
    vecs.push_back('{addr: 3'd3, wr: 1'b1, wdata: 32'h0000_FFFF, exp: 32'h0});
    vecs.push_back('{addr: 3'd3, wr: 1'b0, wdata: 32'h0,         exp: 32'h0});
    vecs.push_back('{addr: 3'd0, wr: 1'b1, wdata: 32'h0,         exp: 32'h0});
    vecs.push_back('{addr: 3'd0, wr: 1'b0, wdata: 32'h0,         exp: 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else read_check(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
    end
    check("regs_out_port", 32'(out_port), 32'h0);
    check("regs_irq", 32'(irq), 32'h0);

    // Read latency: a new address must not reach readdata before the next edge.
    bus.address = 3'd1;
    #1;
    check("rd_latency_hold", bus.readdata, 32'h0);
    @(negedge clk);
    check("rd_latency_update", bus.readdata, 32'h00CD_EF12);

    // Forward full step, PERIOD=4, three steps.
    do_reset();
    bus_write(3'd0, 32'h1);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'd3);
    bus.address = 3'd3;
    for (int k = 1; k <= 13; k++) begin
      int s;
      @(negedge clk);
      s = (k - 1) / 4;
      if (s > 3) s = 3;
      check($sformatf("fwd_out_k%0d", k), 32'(out_port), 32'(coil(2 * s)));
      check($sformatf("fwd_status_k%0d", k), bus.readdata, (k <= 12) ? 32'h1 : 32'h2);
    end
    check("fwd_irq_masked", 32'(irq), 32'h0);
    read_check(3'd2, 32'h0, "fwd_remaining");
    read_check(3'd4, 32'h6, "fwd_phase");

    // Reverse half step with irq, PERIOD=1, two steps.
    do_reset();
    bus_write(3'd0, 32'hF);
    bus_write(3'd1, 32'd1);
    bus_write(3'd2, 32'd2);
    @(negedge clk);
    check("rev_out_k1", 32'(out_port), 32'(coil(0)));
    check("rev_irq_k1", 32'(irq), 32'h0);
    @(negedge clk);
    check("rev_out_k2", 32'(out_port), 32'(coil(7)));
    check("rev_irq_k2", 32'(irq), 32'h1);
    @(negedge clk);
    check("rev_out_k3", 32'(out_port), 32'(coil(6)));
    read_check(3'd4, 32'h6, "rev_phase");
    check("rev_irq_held", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h0);
    check("rev_irq_cleared", 32'(irq), 32'h0);
    read_check(3'd3, 32'h0, "rev_status_cleared");

    // PERIOD=0 behaves as 1.
    do_reset();
    bus_write(3'd0, 32'h1);
    bus_write(3'd2, 32'd1);
    bus.address = 3'd3;
    @(negedge clk);
    check("p0_status_k1", bus.readdata, 32'h1);
    @(negedge clk);
    check("p0_status_k2", bus.readdata, 32'h2);
    check("p0_out_k2", 32'(out_port), 32'(coil(2)));

    // Continuous mode wraps the phase index without touching remaining.
    do_reset();
    bus_write(3'd1, 32'd2);
    bus_write(3'd0, 32'h11);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("cont_out_k%0d", k), 32'(out_port), 32'(coil(2 * ((k - 1) / 2))));
    end
    read_check(3'd2, 32'h0, "cont_remaining");
    bus_write(3'd0, 32'h0);
    @(negedge clk);
    check("cont_stop_out", 32'(out_port), 32'h0);
    read_check(3'd3, 32'h0, "cont_stop_status");

    // Shortening PERIOD mid-count fires the step on the next cycle.
    do_reset();
    bus_write(3'd1, 32'd100);
    bus_write(3'd0, 32'h1);
    bus_write(3'd2, 32'd1000);
    repeat (50) @(negedge clk);
    bus_write(3'd1, 32'd10);
    for (int k = 1; k <= 23; k++) begin
      int j;
      int idx;
      @(negedge clk);
      j = k - 1;
      idx = (j >= 21) ? 6 : (j >= 11) ? 4 : (j >= 1) ? 2 : 0;
      check($sformatf("live_period_out_k%0d", k), 32'(out_port), 32'(coil(idx)));
    end

    // Asynchronous reset while running, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out_port), 32'h0);
    check("async_rst_readdata", bus.readdata, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    read_check(3'd3, 32'h0, "post_rst_status");
    read_check(3'd4, 32'h0, "post_rst_phase");
    check("post_rst_out", 32'(out_port), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
